fphub_div_iter: RTL
===================

# fphub_div_iter

Multi-cycle HUB floating-point divider core with special-case bypass. It sits directly downstream of `special_result_for_divider` and consumes that block's operands, case codes and `special_result`. Non-special operands go through a restoring mantissa divider that produces one quotient bit per cycle. Special operands bypass the divider, and their precomputed result is returned after one cycle. Both ends of the block use valid/ready handshakes.

## Interface
- `M`, default 23: mantissa fraction width.
- `E`, default 8: exponent width.
- `SPECIAL_CASE`, default 7: number of case codes. Codes are `$clog2(SPECIAL_CASE)` bits wide.
- `clk`, input, 1: clock. There is one clock.
- `rst`, input, 1: reset. It is synchronous and active-high.
- `in_valid`, input, 1: an operand pair is offered.
- `in_ready`, output, 1: the block can accept a pair. High only in IDLE.
- `X`, input, E+M+1: dividend as {sign, exponent, fraction}.
- `Y`, input, E+M+1: divisor, same layout.
- `X_special_case`, input, `$clog2(SPECIAL_CASE)`: case code of X.
- `Y_special_case`, input, `$clog2(SPECIAL_CASE)`: case code of Y.
- `special_result`, input, E+M+1: result for the special cases, sampled on accept.
- `out_valid`, output, 1: `Z` is valid.
- `out_ready`, input, 1: the consumer accepts `Z`.
- `Z`, output, E+M+1: quotient.

## Operation
- Case codes: 0 NONE, 1 INF_P, 2 INF_N, 3 ZERO_P, 4 ZERO_N, 5 ONE_P, 6 ONE_N.
- Accept happens when `in_valid && in_ready`.
- Bypass condition: `Y_special_case != NONE`, or `X_special_case` is any INF or ZERO code.
  - On accept with bypass true: latch `special_result` into `Z` and go to DONE.
  - X equal to ONE with Y NONE is **not** a bypass case. It takes the normal divide path.
- Normal path on accept:
  - sign = X[E+M] ^ Y[E+M].
  - Significands are HUB values with an implicit leading 1 and ILSB=1: mx={1,X[M-1:0],1} and my={1,Y[M-1:0],1}, each M+2 bits.
  - Biased exponent: ez = Ex − Ey + BIAS, computed signed in E+2 bits, where BIAS = 2^(E−1)−1.
  - The remainder register is M+3 bits. It is loaded with mx.
- ITER state: runs exactly M+2 cycles, indexed by counter i = 0..M+1. Each cycle:
  - If rem ≥ my: q bit = 1 and rem ← (rem−my)<<1.
  - Otherwise: q bit = 0 and rem ← rem<<1.
  - q shifts in from the LSB. q weights run from 2^0 down to 2^−(M+1).
- Normalize and round, performed when moving from ITER to DONE:
  - If q[M+1] = 1: frac = q[M:1], exponent = ez.
  - Otherwise: frac = q[M−1:0], exponent = ez−1.
  - Rounding is truncation only; HUB round-to-nearest comes from the ILSB.
- Range handling, applied to the final exponent e:
  - e ≥ 2^E−1 → `Z` = {sign, all ones}.
  - e ≤ 0 → `Z` = {sign, all zeros}.
  - Otherwise `Z` = {sign, e[E−1:0], frac}.
- States:
  - IDLE → ITER on accept with bypass false.
  - IDLE → DONE on accept with bypass true.
  - ITER → DONE when i = M+1.
  - DONE → IDLE when `out_ready` is high.
- `Z` and `out_valid` stay stable in DONE until `out_ready` is high.
- `rst` in any state forces IDLE on the next edge and discards any result in flight.

## Timing
- Values held while `rst` is high: `in_ready`=0, `out_valid`=0, `Z`=0. From the first cycle after reset, `in_ready`=1.
- Bypass latency: accept at edge k → `out_valid` high in cycle k+1.
- Normal latency: accept at edge k → `out_valid` high in cycle k+M+3 (M+2 ITER cycles, then DONE).
- Throughput: one operation in flight. `in_ready` is low from the accept edge until the DONE handshake completes.
- A DONE handshake returns to IDLE. A new accept is possible one cycle later; DONE and accept never happen in the same cycle.
- `in_valid` is ignored outside IDLE.

## Structure
- Shared package `fphub_div_pkg` holds:
  - the case-code localparams `CASE_NONE` through `CASE_ONE_N`;
  - the state enum `div_state_t` {IDLE, ITER, DONE};
  - a `BIAS` function of E.
- One sub-module: `hub_mant_div_step`. It is combinational and does one restoring step: (rem, my) → (rem_next, q_bit).
- FSM, counter, exponent logic and output register live in `fphub_div_iter`.

## Test plan
- X=0x3F800000 (ONE_P), Y=0x40000000 (NONE) → divide path (not bypass), `Z`=0x3F000000 after M+3 cycles.
- X=0x40000000, Y=0x3FC00000 → q[M+1]=0 normalization path, `Z`=0x3FAAAAAA.
- X=+0, Y=+0, `special_result`=0xFFFFFFFF → `Z`=0xFFFFFFFF, `out_valid` one cycle after accept.
- X=0x7F000000, Y=0x00800000 → overflow, `Z`=0x7FFFFFFF.
- Normal op with `out_ready` held low for 5 cycles → `Z` and `out_valid` stable, `in_ready`=0 throughout, then exactly one handshake.
- `rst` asserted at ITER cycle 10, then a new op X=Y=0x40400000 → no stale output, `Z`=0x3F800000.

Source files
------------

// File: rtl/fphub_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_div_pkg
//  Description : Shared definitions for the HUB floating-point divider:
//                special-case codes, FSM state type and exponent bias.
//  Revision    : 1.0 - initial release
// ============================================================================
package fphub_div_pkg;

    // Case codes produced by the upstream special-case classifier
    localparam int CASE_NONE   = 0;
    localparam int CASE_INF_P  = 1;
    localparam int CASE_INF_N  = 2;
    localparam int CASE_ZERO_P = 3;
    localparam int CASE_ZERO_N = 4;
    localparam int CASE_ONE_P  = 5;
    localparam int CASE_ONE_N  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Exponent bias for an exponent field of width e_w
    function automatic int BIAS(input int e_w);
        return (1 << (e_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub_mant_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : hub_mant_div_step
//  Description : One restoring-division step on HUB significands.
//                Produces one quotient bit and the shifted partial remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub_mant_div_step
    import fphub_div_pkg::*;
#(
    parameter int M = 23
) (
    input  logic [M+2:0] i_rem,
    input  logic [M+1:0] i_my,
    output logic [M+2:0] o_rem_next,
    output logic         o_q_bit
);

    logic [M+2:0] w_my_ext;
    logic [M+2:0] w_diff;
    logic [M+2:0] w_sel;

    assign w_my_ext = {1'b0, i_my};
    assign w_diff   = i_rem - w_my_ext;
    assign o_q_bit  = (i_rem >= w_my_ext);
    assign w_sel    = o_q_bit ? w_diff : i_rem;
    // The remainder stays below 2*my, so the MSB lost by the shift is always zero
    assign o_rem_next = w_sel << 1;

endmodule
`default_nettype wire

// File: rtl/fphub_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fphub_div_iter
//  Description : Multi-cycle HUB floating-point divider. Non-special operands
//                go through a bit-serial restoring mantissa divider; special
//                operands return the precomputed result after one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fphub_div_iter
    import fphub_div_pkg::*;
#(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int SPECIAL_CASE = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [E+M:0]                    X,
    input  logic [E+M:0]                    Y,
    input  logic [$clog2(SPECIAL_CASE)-1:0] X_special_case,
    input  logic [$clog2(SPECIAL_CASE)-1:0] Y_special_case,
    input  logic [E+M:0]                    special_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [E+M:0]                    Z
);

    localparam int c_CW   = $clog2(SPECIAL_CASE);
    localparam int c_CNTW = $clog2(M + 2);

    div_state_t          r_state;
    div_state_t          w_state_next;

    logic [M+2:0]        r_rem;
    logic [M+1:0]        r_my;
    logic [M:0]          r_q;
    logic [c_CNTW-1:0]   r_cnt;
    logic signed [E+1:0] r_ez;
    logic                r_sign;
    logic [E+M:0]        r_z;

    logic                w_accept;
    logic                w_bypass;
    logic                w_last;
    logic [M+2:0]        w_rem_next;
    logic                w_q_bit;
    logic [M+1:0]        w_q_final;
    logic [M-1:0]        w_frac;
    logic signed [E+1:0] w_ex;
    logic signed [E+1:0] w_ey;
    logic signed [E+1:0] w_bias;
    logic signed [E+1:0] w_ez;
    logic signed [E+1:0] w_e;
    logic                w_ovf;
    logic                w_unf;
    logic [E+M:0]        w_z_norm;

    assign w_accept = in_valid && in_ready;

    // ONE on X with a NONE divisor still divides; only INF/ZERO on X bypass
    assign w_bypass = (Y_special_case != c_CW'(CASE_NONE))
                   || (X_special_case == c_CW'(CASE_INF_P))
                   || (X_special_case == c_CW'(CASE_INF_N))
                   || (X_special_case == c_CW'(CASE_ZERO_P))
                   || (X_special_case == c_CW'(CASE_ZERO_N));

    assign w_last = (r_cnt == c_CNTW'(M + 1));

    // Biased quotient exponent, signed with two guard bits for over/underflow
    assign w_ex   = {2'b00, X[E+M-1:M]};
    assign w_ey   = {2'b00, Y[E+M-1:M]};
    assign w_bias = (E+2)'(BIAS(E));
    assign w_ez   = w_ex - w_ey + w_bias;

    hub_mant_div_step #(
        .M (M)
    ) u_step (
        .i_rem      (r_rem),
        .i_my       (r_my),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    // Quotient including the bit produced in the final iteration
    assign w_q_final = {r_q, w_q_bit};
    assign w_frac    = w_q_final[M+1] ? w_q_final[M:1] : w_q_final[M-1:0];
    assign w_e       = w_q_final[M+1] ? r_ez : (r_ez - (E+2)'(1));
    assign w_ovf     = !w_e[E+1] && (w_e[E:0] >= (E+1)'((1 << E) - 1));
    assign w_unf     = w_e[E+1] || (w_e == '0);

    always_comb begin
        w_z_norm = {r_sign, w_e[E-1:0], w_frac};
        if (w_ovf) begin
            w_z_norm = {r_sign, {(E+M){1'b1}}};
        end else if (w_unf) begin
            w_z_norm = {r_sign, {(E+M){1'b0}}};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    w_state_next = w_bypass ? DONE : ITER;
                end
            end
            ITER: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_my   <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_ez   <= '0;
            r_sign <= 1'b0;
            r_z    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_bypass) begin
                            r_z <= special_result;
                        end else begin
                            r_rem  <= {2'b01, X[M-1:0], 1'b1};
                            r_my   <= {1'b1, Y[M-1:0], 1'b1};
                            r_q    <= '0;
                            r_cnt  <= '0;
                            r_ez   <= w_ez;
                            r_sign <= X[E+M] ^ Y[E+M];
                        end
                    end
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[M-1:0], w_q_bit};
                    r_cnt <= r_cnt + c_CNTW'(1);
                    if (w_last) begin
                        r_z <= w_z_norm;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Z = r_z;

endmodule
`default_nettype wire
